sfifo_ctrl: RTL and testbench

Control stage for the FPGA synchronous FIFO: owns pointers, occupancy and flags, and drives the single-port FIFO memory `sfifo_mem` through its write, read and address ports. The memory gives read priority when both strobes are high, so this block never asserts both in one cycle. It adds a 2-entry first-word-fall-through output stage so `o_data` is valid whenever `o_empty` is low. A top-level FIFO wrapper instantiates this block next to `sfifo_mem` with identical `BW` and `LGFLEN`.

---
 rtl/sfifo_ostage.sv | 57 +++++
 rtl/sfifo_ctrl.sv | 106 ++++++++++
 tb/tb_sfifo_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_ostage.sv
// Two-entry first-word-fall-through output buffer for the synchronous FIFO.
// Head is always the oldest word; the spare slides into head on a pop.
module sfifo_ostage #(
    parameter int BW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [BW-1:0] i_load_data,
    input  logic          i_pop,
    output logic [1:0]    o_occ,
    output logic [BW-1:0] o_head
);

    logic [BW-1:0] head_q, head_d;
    logic [BW-1:0] spare_q, spare_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop_ok;

    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        occ_d   = occ_q;
        pop_ok  = i_pop && (occ_q != 2'd0);

        if (pop_ok) begin
            head_d = spare_q;
            occ_d  = occ_q - 2'd1;
        end

        // A new word lands in the first slot left free after the pop shift.
        if (i_load) begin
            if (occ_d == 2'd0) begin
                head_d = i_load_data;
            end else begin
                spare_d = i_load_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            spare_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            head_q  <= head_d;
            spare_q <= spare_d;
            occ_q   <= occ_d;
        end
    end

    assign o_occ  = occ_q;
    assign o_head = head_q;

endmodule

// File: rtl/sfifo_ctrl.sv
// Pointer, occupancy and memory-port arbitration for the synchronous FIFO.
// Drives a single-port sfifo_mem; writes win the port over prefetch reads.
module sfifo_ctrl #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic [LGFLEN+1:0] o_fill,
    output logic              o_mem_wr,
    output logic [LGFLEN:0]   o_mem_wr_addr,
    output logic [BW-1:0]     o_mem_wdata,
    output logic              o_mem_rd,
    output logic [LGFLEN:0]   o_mem_rd_addr,
    input  logic [BW-1:0]     i_mem_rdata
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam int PW    = LGFLEN + 1;
    localparam int FW    = LGFLEN + 2;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] mem_count_q, mem_count_d;
    logic          rd_inflight_q, rd_inflight_d;

    logic [1:0]    out_occ;
    logic [2:0]    avail;
    logic          wr_acc;
    logic          pop;
    logic          bypass;
    logic          mem_wr;
    logic          mem_rd;
    logic          load;
    logic [BW-1:0] load_data;

    always_comb begin
        o_empty = (out_occ == 2'd0);
        o_full  = (mem_count_q == PW'(DEPTH));
        wr_acc  = i_wr && !o_full;
        pop     = i_rd && !o_empty;
        avail   = 3'(out_occ) + 3'(rd_inflight_q) - 3'(pop);

        // Write straight into the output stage only when nothing older is queued.
        bypass  = wr_acc && (mem_count_q == '0) && !rd_inflight_q && (avail < 3'd2);

        mem_wr  = wr_acc && !bypass && !i_reset;
        mem_rd  = (mem_count_q != '0) && !mem_wr && (avail < 3'd2) && !i_reset;

        load      = bypass || rd_inflight_q;
        load_data = rd_inflight_q ? i_mem_rdata : i_data;

        wr_ptr_d      = wr_ptr_q + PW'(mem_wr);
        rd_ptr_d      = rd_ptr_q + PW'(mem_rd);
        mem_count_d   = mem_count_q + PW'(mem_wr) - PW'(mem_rd);
        rd_inflight_d = mem_rd;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_count_q   <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_count_q   <= mem_count_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    sfifo_ostage #(
        .BW (BW)
    ) u_ostage (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (load),
        .i_load_data (load_data),
        .i_pop       (pop),
        .o_occ       (out_occ),
        .o_head      (o_data)
    );

    // Address MSB is tied low so the memory never sees an index past DEPTH-1.
    assign o_mem_wr      = mem_wr;
    assign o_mem_rd      = mem_rd;
    assign o_mem_wr_addr = {1'b0, wr_ptr_q[LGFLEN-1:0]};
    assign o_mem_rd_addr = {1'b0, rd_ptr_q[LGFLEN-1:0]};
    assign o_mem_wdata   = i_data;
    assign o_fill        = FW'(mem_count_q) + FW'(out_occ) + FW'(rd_inflight_q);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (PW'(wr_ptr_q - rd_ptr_q) == mem_count_q);
            assert (!(mem_wr && mem_rd));
        end
    end

endmodule

// File: tb/tb_sfifo_ctrl.sv
// Self-checking bench for sfifo_ctrl with a behavioural single-port memory
// and a queue-based reference of FIFO contents.
module tb_sfifo_ctrl;

    localparam int BW     = 8;
    localparam int LGFLEN = 2;
    localparam int DEPTH  = 1 << LGFLEN;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              o_full;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;
    logic [LGFLEN+1:0] o_fill;
    logic              o_mem_wr;
    logic [LGFLEN:0]   o_mem_wr_addr;
    logic [BW-1:0]     o_mem_wdata;
    logic              o_mem_rd;
    logic [LGFLEN:0]   o_mem_rd_addr;
    logic [BW-1:0]     i_mem_rdata;

    sfifo_ctrl #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wr          (i_wr),
        .i_data        (i_data),
        .o_full        (o_full),
        .i_rd          (i_rd),
        .o_data        (o_data),
        .o_empty       (o_empty),
        .o_fill        (o_fill),
        .o_mem_wr      (o_mem_wr),
        .o_mem_wr_addr (o_mem_wr_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_rd      (o_mem_rd),
        .o_mem_rd_addr (o_mem_rd_addr),
        .i_mem_rdata   (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Single-port memory: read has priority, read data registered.
    logic [BW-1:0] mem [0:(2*DEPTH)-1];
    logic [BW-1:0] mem_rdata_q;
    always @(posedge i_clk) begin
        if (o_mem_rd) mem_rdata_q <= mem[o_mem_rd_addr];
        else if (o_mem_wr) mem[o_mem_wr_addr] <= o_mem_wdata;
    end
    assign i_mem_rdata = mem_rdata_q;

    int            n_checks = 0;
    int            n_err    = 0;
    int            stall    = 0;
    logic [BW-1:0] q[$];

    logic          obs_mem_wr, obs_mem_rd, obs_full, obs_empty;
    logic [BW-1:0] obs_data;
    logic [LGFLEN+1:0] obs_fill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample at negedge, check, update the reference.
    task automatic cycle(input logic wr, input logic [BW-1:0] d, input logic rd);
        i_wr = wr; i_data = d; i_rd = rd;
        @(negedge i_clk);
        obs_mem_wr = o_mem_wr; obs_mem_rd = o_mem_rd; obs_full = o_full;
        obs_empty  = o_empty;  obs_data   = o_data;   obs_fill = o_fill;

        chk("strobe_excl", 32'(o_mem_wr & o_mem_rd), 0);
        chk("wr_addr_msb", 32'(o_mem_wr_addr[LGFLEN]), 0);
        chk("rd_addr_msb", 32'(o_mem_rd_addr[LGFLEN]), 0);
        if (o_mem_wr) chk("mem_wdata", 32'(o_mem_wdata), 32'(d));
        chk("fill", 32'(o_fill), q.size());
        if (q.size() == 0) chk("empty_when_none", 32'(o_empty), 1);
        if (!o_empty && q.size() != 0) chk("head", 32'(o_data), 32'(q[0]));
        if (q.size() < DEPTH) chk("full_early", 32'(o_full), 0);
        if (q.size() == DEPTH + 2) chk("full_at_max", 32'(o_full), 1);

        if (o_mem_wr) stall = 0;
        else if (q.size() != 0 && o_empty) stall++;
        else stall = 0;
        if (q.size() != 0) chk("stall_bound", 32'(stall > 3), 0);

        if (rd && !o_empty && q.size() != 0) void'(q.pop_front());
        if (wr && !o_full) q.push_back(d);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_data = '0;
        repeat (n) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_empty",  32'(o_empty),  1);
        chk("rst_full",   32'(o_full),   0);
        chk("rst_fill",   32'(o_fill),   0);
        chk("rst_data",   32'(o_data),   0);
        chk("rst_mem_wr", 32'(o_mem_wr), 0);
        chk("rst_mem_rd", 32'(o_mem_rd), 0);
        i_reset = 1'b0;
        q.delete();
        stall = 0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain_all();
        int budget = 40;
        while (q.size() != 0 && budget > 0) begin
            cycle(1'b0, '0, 1'b1);
            budget--;
        end
        chk("drain_done", q.size(), 0);
        cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout n_err=%0d n_checks=%0d", n_err, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_data = '0;
        do_reset(2);

        // Bypass into an empty FIFO.
        cycle(1'b1, 8'hA5, 1'b0);
        chk("byp_no_memwr", 32'(obs_mem_wr), 0);
        cycle(1'b0, '0, 1'b0);
        chk("byp_empty", 32'(obs_empty), 0);
        chk("byp_data",  32'(obs_data),  32'h A5);
        chk("byp_fill",  32'(obs_fill),  1);
        drain_all();

        // Fill to full: two bypassed, four to memory, seventh dropped.
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b1, 8'(k), 1'b0);
            chk($sformatf("fill_memwr%0d", k), 32'(obs_mem_wr), 32'(k >= 3 && k <= 6));
            if (k == 7) chk("full_after6", 32'(obs_full), 1);
        end
        cycle(1'b0, '0, 1'b0);
        chk("full_fill", 32'(obs_fill), 6);
        chk("full_flag", 32'(obs_full), 1);
        chk("full_head", 32'(obs_data), 1);

        // Drain with continuous reads: no gaps.
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, '0, 1'b1);
            chk($sformatf("drain_empty%0d", k), 32'(obs_empty), 0);
            chk($sformatf("drain_data%0d", k),  32'(obs_data),  32'(k));
        end
        cycle(1'b0, '0, 1'b0);
        chk("drain_end_empty", 32'(obs_empty), 1);
        chk("drain_end_fill",  32'(obs_fill),  0);

        // Simultaneous read and write every cycle.
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 8'(8'h40 + k), 1'b1);
            chk("sim_full", 32'(obs_full), 0);
            chk("sim_fill_bound", 32'(obs_fill <= 2), 1);
        end
        drain_all();

        // Wrap-around: repeated fill 4 / drain 4.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h80 + r * 4 + i), 1'b0);
            drain_all();
        end

        // Reset while a prefetch is in flight.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("mid_rd_strobe", 32'(obs_mem_rd), 1);
        do_reset(1);
        cycle(1'b0, '0, 1'b0);
        chk("mid_rst_empty", 32'(obs_empty), 1);
        chk("mid_rst_fill",  32'(obs_fill),  0);
        chk("mid_rst_data",  32'(obs_data),  0);

        // Randomized traffic with shifting write/read bias.
        for (int blk = 0; blk < 8; blk++) begin
            int pw;
            int pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 50; c++) begin
                cycle(32'($urandom_range(0, 99)) < pw, 8'($urandom), 32'($urandom_range(0, 99)) < pr);
            end
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
